// File: rtl/rv_data_bus_router.sv
// Single-master data-bus router: decodes the LSU address against per-slave
// base/mask windows and runs one slave transaction at a time, with an error response.
module rv_data_bus_router #(
   parameter int unsigned               XLEN        = 32,
   parameter int unsigned               N_DEV       = 3,
   parameter logic [31:0]               ADDRESS_HEX = 32'h1000_0000,
   parameter logic [N_DEV*XLEN-1:0]     DEV_BASE    = {32'h0, ADDRESS_HEX, 32'h0},
   parameter logic [N_DEV*XLEN-1:0]     DEV_MASK    = {32'h0, 32'hFFFF_FFFF, 32'hFFFF_0000},
   parameter int unsigned               TIMEOUT     = 16
) (
   input  logic                     clk_i,
   input  logic                     arstn_i,
   input  logic                     data_req_i,
   output logic                     data_gnt_o,
   input  logic                     data_we_i,
   input  logic [XLEN/8-1:0]        data_be_i,
   input  logic [XLEN-1:0]          data_addr_i,
   input  logic [XLEN-1:0]          data_wdata_i,
   output logic                     data_rvalid_o,
   output logic [XLEN-1:0]          data_rdata_o,
   output logic                     data_err_o,
   output logic [N_DEV-1:0]         dev_req_o,
   output logic                     dev_we_o,
   output logic [XLEN/8-1:0]        dev_be_o,
   output logic [XLEN-1:0]          dev_addr_o,
   output logic [XLEN-1:0]          dev_wdata_o,
   input  logic [N_DEV-1:0]         dev_rvalid_i,
   input  logic [N_DEV*XLEN-1:0]    dev_rdata_i
);

   localparam int unsigned SEL_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned BE_W  = XLEN / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP,
      S_ERR
   } state_e;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0]    cap_q, cap_d;
   logic [N_DEV-1:0]   dev_req_q, dev_req_d;
   logic               dev_we_q, dev_we_d;
   logic [BE_W-1:0]    dev_be_q, dev_be_d;
   logic [XLEN-1:0]    dev_addr_q, dev_addr_d;
   logic [XLEN-1:0]    dev_wdata_q, dev_wdata_d;
   logic               rvalid_q, rvalid_d;
   logic               err_q, err_d;
   logic [XLEN-1:0]    rdata_q, rdata_d;

   logic               hit;
   logic [SEL_W-1:0]   hit_idx;
   logic [N_DEV-1:0]   hit_oh;
   logic               sel_rvalid;
   logic [XLEN-1:0]    sel_rdata;

   // Descending scan so the lowest matching index is the last one written.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      hit_oh  = '0;
      for (int k = N_DEV - 1; k >= 0; k--) begin
         if ((data_addr_i & DEV_MASK[k*XLEN +: XLEN]) == DEV_BASE[k*XLEN +: XLEN]) begin
            hit       = 1'b1;
            hit_idx   = SEL_W'(k);
            hit_oh    = '0;
            hit_oh[k] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_rvalid = 1'b0;
      sel_rdata  = '0;
      for (int k = 0; k < N_DEV; k++) begin
         if (sel_q == SEL_W'(k)) begin
            sel_rvalid = dev_rvalid_i[k];
            sel_rdata  = dev_rdata_i[k*XLEN +: XLEN];
         end
      end
   end

   // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      cap_d       = cap_q;
      dev_req_d   = '0;
      dev_we_d    = dev_we_q;
      dev_be_d    = dev_be_q;
      dev_addr_d  = dev_addr_q;
      dev_wdata_d = dev_wdata_q;
      rvalid_d    = 1'b0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;

      unique case (state_q)
         S_IDLE: begin
            if (data_req_i) begin
               if (hit) begin
                  dev_we_d    = data_we_i;
                  dev_be_d    = data_be_i;
                  dev_addr_d  = data_addr_i;
                  dev_wdata_d = data_wdata_i;
                  sel_d       = hit_idx;
                  dev_req_d   = hit_oh;
                  state_d     = S_REQ;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_REQ: begin
            cnt_d = '0;
            if (sel_rvalid) begin
               cap_d   = sel_rdata;
               state_d = S_RESP;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // A response in the final wait cycle still beats the timeout.
            if (sel_rvalid) begin
               cap_d   = sel_rdata;
               state_d = S_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            rvalid_d = 1'b1;
            rdata_d  = cap_q;
            state_d  = S_IDLE;
         end
         S_ERR: begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         cnt_q       <= '0;
         cap_q       <= '0;
         dev_req_q   <= '0;
         dev_we_q    <= 1'b0;
         dev_be_q    <= '0;
         dev_addr_q  <= '0;
         dev_wdata_q <= '0;
         rvalid_q    <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         cap_q       <= cap_d;
         dev_req_q   <= dev_req_d;
         dev_we_q    <= dev_we_d;
         dev_be_q    <= dev_be_d;
         dev_addr_q  <= dev_addr_d;
         dev_wdata_q <= dev_wdata_d;
         rvalid_q    <= rvalid_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
      end
   end

   assign data_gnt_o    = (state_q == S_IDLE);
   assign data_rvalid_o = rvalid_q;
   assign data_err_o    = err_q;
   assign data_rdata_o  = rdata_q;
   assign dev_req_o     = dev_req_q;
   assign dev_we_o      = dev_we_q;
   assign dev_be_o      = dev_be_q;
   assign dev_addr_o    = dev_addr_q;
   assign dev_wdata_o   = dev_wdata_q;

endmodule
